// File: rtl/ALU_FNS.sv
// Shared ALU function/funct7 encodings and the RV32 opcode constants used by the decode stage.
package ALU_FNS;

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } alu_fn_t;

    typedef enum logic {
        ADD_SRL = 1'b0,
        SUB_SRA = 1'b1
    } funct7_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode_stage_skid_buffer.sv
// Two-entry FIFO between the decoder and downstream; in_ready comes straight from a flop.
module skid_buffer #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          r_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_count_nxt;

    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = (r_count != 2'd0) && out_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];

    // Entries are cleared on reset so the idle bundle reads as all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32 OP/OP-IMM decoder feeding a 2-entry buffer.
// Optional DECODE_PERF_CNT_EN adds a 32-bit count of delivered bundles.
module alu_decode_stage
    import ALU_FNS::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_fn_t          fn,
    output funct7_t          funct7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [WIDTH-1:0] imm,
    output logic             use_imm,
`ifdef DECODE_PERF_CNT_EN
    output logic [31:0]      decode_cnt,
`endif
    output logic             illegal
);

    localparam int unsigned PW = WIDTH + 21;

    logic [6:0]       w_opcode;
    logic [6:0]       w_f7_field;
    alu_fn_t          w_fn;
    funct7_t          w_funct7;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [WIDTH-1:0] w_imm;
    logic             w_use_imm;
    logic             w_illegal;
    logic [PW-1:0]    w_in_data;
    logic [PW-1:0]    w_out_data;
    logic [2:0]       w_fn_bits;
    logic             w_funct7_bit;

    assign w_opcode   = instr[6:0];
    assign w_f7_field = instr[31:25];

    always_comb begin
        w_fn      = ADD_SUB;
        w_funct7  = ADD_SRL;
        w_rd      = instr[11:7];
        w_rs1     = instr[19:15];
        w_rs2     = instr[24:20];
        w_imm     = '0;
        w_use_imm = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_fn     = alu_fn_t'(instr[14:12]);
                w_funct7 = instr[30] ? SUB_SRA : ADD_SRL;
                if (w_f7_field == F7_ZERO) begin
                    w_illegal = 1'b0;
                end else if (w_f7_field == F7_ALT) begin
                    w_illegal = !((w_fn == ADD_SUB) || (w_fn == SRL_SRA));
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_fn      = alu_fn_t'(instr[14:12]);
                w_use_imm = 1'b1;
                w_rs2     = '0;
                w_imm     = {{(WIDTH-12){instr[31]}}, instr[31:20]};
                // Shifts carry a 5-bit shamt; the upper bits are funct7, not immediate.
                if (w_fn == SLL) begin
                    w_imm     = {{(WIDTH-5){1'b0}}, instr[24:20]};
                    w_illegal = (w_f7_field != F7_ZERO);
                end else if (w_fn == SRL_SRA) begin
                    w_imm     = {{(WIDTH-5){1'b0}}, instr[24:20]};
                    w_funct7  = instr[30] ? SUB_SRA : ADD_SRL;
                    w_illegal = !((w_f7_field == F7_ZERO) || (w_f7_field == F7_ALT));
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_in_data = {w_fn, w_funct7, w_rd, w_rs1, w_rs2, w_imm, w_use_imm, w_illegal};

    skid_buffer #(
        .DW (PW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign {w_fn_bits, w_funct7_bit, rd, rs1, rs2, imm, use_imm, illegal} = w_out_data;
    assign fn     = alu_fn_t'(w_fn_bits);
    assign funct7 = funct7_t'(w_funct7_bit);

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_decode_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_decode_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_decode_cnt <= r_decode_cnt + 32'd1;
        end
    end

    assign decode_cnt = r_decode_cnt;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: reference decoder plus queue model, checked every cycle.
module tb_alu_decode_stage;
    import ALU_FNS::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    alu_fn_t     fn;
    funct7_t     funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] decode_cnt;
    int unsigned m_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] q[$];
    bit          armed = 0;
    bit          fields_zero = 0;
    logic [63:0] dut_pk;

    alu_decode_stage #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fn        (fn),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .use_imm   (use_imm),
`ifdef DECODE_PERF_CNT_EN
        .decode_cnt(decode_cnt),
`endif
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [2:0] f, input logic s, input logic [4:0] d,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [31:0] im, input logic u, input logic il);
        return {11'b0, f, s, d, a, b, im, u, il};
    endfunction

    always_comb dut_pk = pk(fn, funct7, rd, rs1, rs2, imm, use_imm, illegal);

    // Reference decoder written directly from the instruction-format rules.
    function automatic logic [63:0] ref_decode(input logic [31:0] ins);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  f;
        logic        s;
        logic [4:0]  b;
        logic [31:0] im;
        logic        u;
        logic        il;
        f3 = ins[14:12];
        f7 = ins[31:25];
        f = 3'd0; s = 1'b0; b = ins[24:20]; im = 32'd0; u = 1'b0; il = 1'b0;
        if (ins[6:0] == 7'h33) begin
            f  = f3;
            s  = ins[30];
            il = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (ins[6:0] == 7'h13) begin
            f = f3;
            u = 1'b1;
            b = 5'd0;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                im = {27'd0, ins[24:20]};
                s  = (f3 == 3'd5) && ins[30];
                il = (f3 == 3'd1) ? (f7 != 7'h00) : !(f7 == 7'h00 || f7 == 7'h20);
            end else begin
                im = {{20{ins[31]}}, ins[31:20]};
            end
        end else begin
            il = 1'b1;
        end
        return pk(f, s, ins[11:7], ins[19:15], b, im, u, il);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation for the bundle currently at the head of the buffer.
    task automatic exp_front(input string name, input logic [2:0] f, input logic s,
                             input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                             input logic [31:0] im, input logic u, input logic il);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk(name, dut_pk, pk(f, s, d, a, b, im, u, il));
    endtask

    // Checks at negedge, then advances the model with the handshakes the next edge will take.
    always @(negedge clk) begin
        bit push;
        bit pop;
        if (armed) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
            if (q.size() != 0) chk("bundle", dut_pk, q[0]);
            else if (fields_zero) chk("reset_fields", dut_pk, 64'd0);
`ifdef DECODE_PERF_CNT_EN
            chk("decode_cnt", {32'd0, decode_cnt}, {32'd0, m_cnt});
`endif
        end
        if (rst) begin
            q.delete();
            armed       = 1;
            fields_zero = 1;
`ifdef DECODE_PERF_CNT_EN
            m_cnt = 0;
`endif
        end else if (armed) begin
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() != 0);
            if (pop) begin
                void'(q.pop_front());
`ifdef DECODE_PERF_CNT_EN
                m_cnt++;
`endif
            end
            if (push) begin
                q.push_back(ref_decode(instr));
                fields_zero = 0;
            end
        end
    end

    task automatic send(input logic [31:0] ins);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        instr    = ins;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", {63'd0, done}, 64'd1);
        in_valid = 1'b0;
    endtask

    logic [31:0] extra [6] = '{32'h00209093, 32'h0200D093, 32'h4020F0B3,
                               32'h00C0E613, 32'h8000A113, 32'h4020D0B3};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        send(32'h002081B3);
        exp_front("add", 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        send(32'h402081B3);
        exp_front("sub", 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        send(32'h40335293);
        exp_front("srai", 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        send(32'hFFF00093);
        exp_front("addi_m1", 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        send(32'h40000093);
        exp_front("addi_b30", 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000400, 1'b1, 1'b0);
        @(posedge clk); #1;
        send(32'h00000073);
        exp_front("ecall_ill", 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        send(32'h02208033);
        exp_front("mul_ill", 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1);
        @(posedge clk); #1;

        foreach (extra[i]) send(extra[i]);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: three back-to-back, only two fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        @(posedge clk); #1 instr = 32'h40335293;
        @(posedge clk); #1 instr = 32'hFFF00093;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        exp_front("bp_head", 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_front("bp_hold", 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_front("bp_second", 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b1, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        exp_front("bp_third", 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset with two buffered, while also pushing and popping.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h402081B3;
        @(posedge clk); #1 instr = 32'h00209093;
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst2_fields", dut_pk, 64'd0);
`ifdef DECODE_PERF_CNT_EN
        chk("rst2_cnt", {32'd0, decode_cnt}, 64'd0);
`endif
        send(32'h40335293);
        exp_front("post_rst", 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting the data-path width of imm.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), instr (input, 32): the instruction upstream handshake.
REQ-005 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the decoded-bundle downstream handshake.
REQ-006 SHALL have outputs fn (alu_fn_t), funct7 (funct7_t), rd/rs1/rs2 (5 each), imm (WIDTH), use_imm (1), illegal (1): the decoded bundle, valid while out_valid=1.

Function
REQ-007 SHALL accept instr when in_valid&&in_ready, and pop a bundle when out_valid&&out_ready.
REQ-008 SHALL buffer up to 2 decoded bundles in FIFO order; in_ready = buffer not full, driven from a register only.
REQ-009 SHALL have a latency of 1 cycle: a bundle accepted into an empty buffer asserts out_valid on the next cycle.
REQ-010 SHALL, with the buffer full and a pop occurring, keep in_ready=0 that cycle; a push into a 1-entry buffer with a simultaneous pop leaves occupancy at 1.
REQ-011 SHALL hold every bundle field stable while out_valid=1 and out_ready=0.
REQ-012 SHALL, for opcode OP (0110011): fn=instr[14:12], rs1/rs2/rd from standard fields, use_imm=0, imm=0, funct7=SUB_SRA if instr[30] else ADD_SRL.
REQ-013 SHALL, for OP, set illegal=1 if instr[31:25] is neither 0000000 nor 0100000, or is 0100000 with fn not ADD_SUB/SRL_SRA.
REQ-014 SHALL, for opcode OP-IMM (0010011): use_imm=1, rs2=0, imm=sign-extended instr[31:20] to WIDTH, funct7=ADD_SRL.
REQ-015 SHALL, for OP-IMM shifts (SLL, SRL_SRA): imm=zero-extended instr[24:20]; funct7=SUB_SRA only for SRL_SRA with instr[30]=1.
REQ-016 SHALL, for OP-IMM, set illegal=1 for SLL with instr[31:25]!=0 or SRL_SRA with instr[31:25] not 0000000/0100000.
REQ-017 SHALL, for any other opcode, set illegal=1, fn=ADD_SUB, funct7=ADD_SRL, use_imm=0, imm=0, register fields decoded as for OP.
REQ-018 SHALL pass illegal bundles downstream like any other bundle; never stall or drop them.

Reset
REQ-019 SHALL, on rst, empty the buffer: out_valid=0, in_ready=1 on the following cycle, all bundle fields 0.
REQ-020 SHALL discard any bundle pending or being accepted in a reset cycle; rst dominates simultaneous push/pop.

Configuration
REQ-021 SHALL, with DECODE_PERF_CNT_EN defined, add output decode_cnt (32) counting out handshakes, reset to 0, wrapping 0xFFFFFFFF->0.
REQ-022 SHALL, without DECODE_PERF_CNT_EN, omit decode_cnt and its logic entirely; all other behaviour identical.

Structure
REQ-023 SHALL reuse alu_fn_t, funct7_t, ADD_SRL, SUB_SRA from package ALU_FNS and add opcode constants OPC_OP, OPC_OP_IMM there.
REQ-024 SHALL place the 2-entry buffer in sub-module skid_buffer, parameterised by payload width; decode logic is combinational ahead of it.

Verification
REQ-025 SHALL test 0x002081B3 (add x3,x1,x2) -> fn=ADD_SUB, funct7=ADD_SRL, rd=3, rs1=1, rs2=2, use_imm=0, illegal=0, one cycle later.
REQ-026 SHALL test 0x402081B3 (sub) -> funct7=SUB_SRA; 0x40335293 (srai x5,x6,3) -> fn=SRL_SRA, funct7=SUB_SRA, imm=3, rd=5, rs1=6.
REQ-027 SHALL test 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, use_imm=1, funct7=ADD_SRL; 0x40000093 -> funct7=ADD_SRL (no subtract-immediate).
REQ-028 SHALL test 0x00000073 and 0x02208033 -> illegal=1, fn=ADD_SUB, bundle still delivered.
REQ-029 SHALL test out_ready=0 with 3 back-to-back instructions -> 2 accepted, in_ready=0, outputs stable; out_ready=1 -> drained in order, third accepted.
REQ-030 SHALL test rst asserted with 2 bundles buffered -> out_valid=0, in_ready=1 next cycle; decode_cnt=0 when DECODE_PERF_CNT_EN defined.
